// File: rtl/riscv_irq_arbiter_if.sv
// Interrupt arbiter bus: raw sources, mask port, grant and ack.
// master = event unit/core side, slave = arbiter side.
interface riscv_irq_arbiter_if #(
  parameter int NUM_IRQ = 32
);
  logic [NUM_IRQ-1:0] irq_lines;
  logic [NUM_IRQ-1:0] irq_sec_lines;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic [NUM_IRQ-1:0] mask;
  logic               irq;
  logic [4:0]         irq_id;
  logic               irq_sec;
  logic               irq_ack;
  logic [4:0]         irq_ack_id;
  logic [NUM_IRQ-1:0] pending;

  modport master (
    output irq_lines, irq_sec_lines,
    output mask_we, mask_wdata,
    output irq_ack, irq_ack_id,
    input  mask, irq, irq_id, irq_sec, pending
  );

  modport slave (
    input  irq_lines, irq_sec_lines,
    input  mask_we, mask_wdata,
    input  irq_ack, irq_ack_id,
    output mask, irq, irq_id, irq_sec, pending
  );
endinterface

// File: rtl/riscv_irq_arbiter.sv
// Masked fixed-priority interrupt arbiter feeding the core's irq controller.
// Define RISCV_IRQ_ARB_EDGE_EN for edge-triggered sources (level otherwise).
module riscv_irq_arbiter #(
  parameter int NUM_IRQ      = 32,
  parameter bit HIGH_ID_WINS = 1'b1
) (
  input logic               clk,
  input logic               rst,
  riscv_irq_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACKED
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] elig;
  logic [31:0]        elig_x;
  logic [31:0]        sec_x;
  logic [4:0]         win;
  logic               irq_q;
  logic [4:0]         id_q;
  logic               sec_q;
  logic               ack_hit;

  assign elig    = pend & mask_q;
  assign elig_x  = 32'(elig);
  assign sec_x   = 32'(bus.irq_sec_lines);
  assign ack_hit = (state == REQ) && bus.irq_ack
                && (bus.irq_ack_id == id_q);

  // Later hits overwrite earlier ones, so scan order sets the priority.
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig[HIGH_ID_WINS ? i : NUM_IRQ-1-i])
        win = 5'(HIGH_ID_WINS ? i : NUM_IRQ-1-i);
    end
  end

`ifdef RISCV_IRQ_ARB_EDGE_EN
  logic [NUM_IRQ-1:0] line_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;

  assign rise = bus.irq_lines & ~line_q;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      clr[i] = ack_hit && (id_q == 5'(i));
  end

  // History resets high: a line already high at release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '1;
      pend   <= '0;
    end else begin
      line_q <= bus.irq_lines;
      pend   <= (pend & ~clr) | rise;
    end
  end
`else
  assign pend = bus.irq_lines;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mask_q <= '0;
      irq_q  <= 1'b0;
      id_q   <= '0;
      sec_q  <= 1'b0;
    end else begin
      if (bus.mask_we)
        mask_q <= bus.mask_wdata;
      unique case (state)
        IDLE: begin
          if (|elig) begin
            state <= REQ;
            irq_q <= 1'b1;
            id_q  <= win;
            sec_q <= sec_x[win];
          end
        end
        REQ: begin
          if (ack_hit) begin
            state <= ACKED;
            irq_q <= 1'b0;
            sec_q <= 1'b0;
          end else if (!elig_x[id_q]) begin
            state <= IDLE;
            irq_q <= 1'b0;
            sec_q <= 1'b0;
          end
        end
        ACKED: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq_q <= 1'b0;
          sec_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mask    = mask_q;
  assign bus.irq     = irq_q;
  assign bus.irq_id  = id_q;
  assign bus.irq_sec = sec_q;
  assign bus.pending = elig;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Directed scoreboard bench for riscv_irq_arbiter (level or edge build).
// Expected grant outputs are queued per step and popped after the clock.
module tb_riscv_irq_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  riscv_irq_arbiter_if #(.NUM_IRQ(32)) bus ();

  riscv_irq_arbiter #(
    .NUM_IRQ(32),
    .HIGH_ID_WINS(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      tag;
    logic       irq;
    logic [4:0] id;
    logic       sec;
  } exp_t;

  exp_t sbq[$];

  function automatic logic [31:0] b(int n);
    return 32'd1 << n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_empty got=none exp=entry");
    end else begin
      e = sbq.pop_front();
      assert ({bus.irq, bus.irq_id, bus.irq_sec}
              === {e.irq, e.id, e.sec})
      else begin
        bad++;
        $error("FAIL %s got irq=%0b id=%0d sec=%0b exp irq=%0b id=%0d sec=%0b",
               e.tag, bus.irq, bus.irq_id, bus.irq_sec,
               e.irq, e.id, e.sec);
      end
    end
  endtask

  task automatic step(string tag, logic i,
                      logic [4:0] id, logic s);
    exp_t e;
    e.tag = tag;
    e.irq = i;
    e.id  = id;
    e.sec = s;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    pop_check();
  endtask

  initial begin
    rst               = 1'b1;
    bus.irq_lines     = '1;
    bus.irq_sec_lines = '0;
    bus.mask_we       = 1'b1;
    bus.mask_wdata    = '1;
    bus.irq_ack       = 1'b0;
    bus.irq_ack_id    = '0;

    @(negedge clk);
    chk("t1_rst_irq", 32'(bus.irq), 32'd0);
    chk("t1_rst_id", 32'(bus.irq_id), 32'd0);
    chk("t1_rst_mask", bus.mask, 32'd0);
    step("t1_rst_hold", 1'b0, 5'd0, 1'b0);
    rst         = 1'b0;
    bus.mask_we = 1'b0;
    step("t1_post", 1'b0, 5'd0, 1'b0);
    chk("t1_post_mask", bus.mask, 32'd0);

`ifndef RISCV_IRQ_ARB_EDGE_EN
    bus.irq_lines = '0;
    bus.mask_we   = 1'b1;
    step("mask_set", 1'b0, 5'd0, 1'b0);
    bus.mask_we = 1'b0;
    chk("mask_o", bus.mask, 32'hffff_ffff);

    bus.irq_sec_lines = b(17);
    bus.irq_lines     = b(3) | b(17);
    step("t2_prio", 1'b1, 5'd17, 1'b1);
    chk("t2_pend", bus.pending, b(3) | b(17));
    bus.irq_ack    = 1'b1;
    bus.irq_ack_id = 5'd17;
    bus.irq_lines  = b(3);
    step("t2_acked", 1'b0, 5'd17, 1'b0);
    bus.irq_ack = 1'b0;
    step("t2_idle", 1'b0, 5'd17, 1'b0);
    step("t2_next", 1'b1, 5'd3, 1'b0);

    bus.irq_lines = b(5);
    step("t3_wd3", 1'b0, 5'd3, 1'b0);
    step("t3_grant5", 1'b1, 5'd5, 1'b0);
    bus.irq_lines = b(5) | b(20);
    step("t3_hold", 1'b1, 5'd5, 1'b0);
    step("t3_hold2", 1'b1, 5'd5, 1'b0);
    bus.irq_ack    = 1'b1;
    bus.irq_ack_id = 5'd4;
    step("t3_badack", 1'b1, 5'd5, 1'b0);
    bus.irq_ack_id = 5'd5;
    bus.irq_lines  = b(20);
    step("t3_ack5", 1'b0, 5'd5, 1'b0);
    bus.irq_ack = 1'b0;
    step("t3_idle", 1'b0, 5'd5, 1'b0);
    step("t3_grant20", 1'b1, 5'd20, 1'b0);

    bus.irq_lines = b(9);
    step("t4_wd20", 1'b0, 5'd20, 1'b0);
    step("t4_grant9", 1'b1, 5'd9, 1'b0);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = ~b(9);
    step("t4_maskwr", 1'b1, 5'd9, 1'b0);
    bus.mask_we = 1'b0;
    step("t4_withdraw", 1'b0, 5'd9, 1'b0);
    chk("t4_pend", bus.pending, 32'd0);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = '1;
    step("t4_unmask", 1'b0, 5'd9, 1'b0);
    bus.mask_we = 1'b0;
    step("t4_regrant", 1'b1, 5'd9, 1'b0);
    bus.irq_ack    = 1'b1;
    bus.irq_ack_id = 5'd9;
    bus.irq_lines  = '0;
    step("t4_ackwd", 1'b0, 5'd9, 1'b0);
    bus.irq_ack   = 1'b0;
    bus.irq_lines = b(9);
    step("t4_acked", 1'b0, 5'd9, 1'b0);
    step("t4_grant", 1'b1, 5'd9, 1'b0);

    rst = 1'b1;
    #1;
    chk("t6_async", 32'(bus.irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step("t6_rel", 1'b0, 5'd0, 1'b0);
    chk("t6_mask", bus.mask, 32'd0);
    bus.mask_we = 1'b1;
    step("t6_mask_wr", 1'b0, 5'd0, 1'b0);
    bus.mask_we = 1'b0;
    step("t6_fresh", 1'b1, 5'd9, 1'b0);
`else
    bus.irq_lines  = '0;
    bus.mask_we    = 1'b1;
    bus.mask_wdata = ~b(2);
    step("e_mask", 1'b0, 5'd0, 1'b0);
    bus.mask_we = 1'b0;

    bus.irq_lines = b(2);
    step("t5_pulse", 1'b0, 5'd0, 1'b0);
    bus.irq_lines = '0;
    chk("t5_pend_masked", bus.pending, 32'd0);
    step("t5_masked", 1'b0, 5'd0, 1'b0);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = '1;
    step("t5_unmask", 1'b0, 5'd0, 1'b0);
    bus.mask_we = 1'b0;
    chk("t5_pend_vis", bus.pending, b(2));
    step("t5_grant", 1'b1, 5'd2, 1'b0);
    bus.irq_ack    = 1'b1;
    bus.irq_ack_id = 5'd2;
    bus.irq_lines  = b(2);
    step("t5_ack_repend", 1'b0, 5'd2, 1'b0);
    bus.irq_ack   = 1'b0;
    bus.irq_lines = '0;
    chk("t5_repend", bus.pending, b(2));
    step("t5_idle", 1'b0, 5'd2, 1'b0);
    step("t5_regrant", 1'b1, 5'd2, 1'b0);
    bus.irq_ack = 1'b1;
    step("t5_ack", 1'b0, 5'd2, 1'b0);
    bus.irq_ack = 1'b0;
    chk("t5_pend_clr", bus.pending, 32'd0);
    step("t5_idle2", 1'b0, 5'd2, 1'b0);
    step("t5_quiet", 1'b0, 5'd2, 1'b0);

    bus.irq_lines = b(7);
    step("t6_pulse", 1'b0, 5'd2, 1'b0);
    bus.irq_lines = '0;
    step("t6_grant", 1'b1, 5'd7, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_async", 32'(bus.irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step("t6_rel", 1'b0, 5'd0, 1'b0);
    bus.mask_we = 1'b1;
    step("t6_mask_wr", 1'b0, 5'd0, 1'b0);
    bus.mask_we = 1'b0;
    step("t6_nogrant", 1'b0, 5'd0, 1'b0);
    chk("t6_pend_lost", bus.pending, 32'd0);
    bus.irq_lines = b(7);
    step("t6_fresh_pend", 1'b0, 5'd0, 1'b0);
    bus.irq_lines = '0;
    step("t6_fresh", 1'b1, 5'd7, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
